periph_bus_arbiter: RTL

- Shares the single memory-mapped peripheral bus (Read, Write, addr, wdata, rdata at 0x40000000–0x40000014) between two masters: m0 = CPU data port, m1 = DMA/loader.
- Per-cycle round-robin arbitration with optional short locked bursts.
- Registered command stage toward the peripherals; registered ack and read data back to the granted master.
- Out-of-range or misaligned accesses are rejected with an error ack and never reach the bus.

---
 rtl/periph_bus_pkg.sv | 36 +++
 rtl/periph_bus_arbiter_if.sv | 29 ++
 rtl/rr_arbiter2.sv | 88 ++++++++
 rtl/periph_bus_arbiter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/periph_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : periph_bus_pkg
//  Brief    : Shared constants and helpers for the peripheral bus arbiter:
//             peripheral register map, master index encoding, address check.
//  Revision : 1.0  initial release
// ============================================================================
package periph_bus_pkg;

   // Peripheral register map
   localparam logic [31:0] PERIPH_BASE     = 32'h4000_0000;
   localparam logic [31:0] REG_TH          = 32'h0000_0000;
   localparam logic [31:0] REG_TL          = 32'h0000_0004;
   localparam logic [31:0] REG_TCON        = 32'h0000_0008;
   localparam logic [31:0] REG_LEDS        = 32'h0000_000C;
   localparam logic [31:0] REG_DIGI        = 32'h0000_0010;
   localparam logic [31:0] REG_SYSTICK     = 32'h0000_0014;
   localparam int          PERIPH_NUM_REGS = 6;

   // Master index encoding
   typedef enum logic {
      M_CPU = 1'b0,
      M_DMA = 1'b1
   } master_e;

   // Word-aligned and inside the decoded register window
   function automatic logic addr_valid(input logic [31:0] a,
                                       input logic [31:0] base,
                                       input int          nregs);
      logic [31:0] last;
      last = base + 32'(4 * (nregs - 1));
      return (a[1:0] == 2'b00) && (a >= base) && (a <= last);
   endfunction

endpackage : periph_bus_pkg
`default_nettype wire

// File: rtl/periph_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : periph_bus_arbiter_if
//  Brief    : Per-master request/response channel of the peripheral arbiter.
//             master modport = requester side, slave modport = arbiter side.
//  Revision : 1.0  initial release
// ============================================================================
interface periph_bus_arbiter_if;
   logic        req;
   logic        we;
   logic        lock;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        gnt;
   logic        ack;
   logic        err;
   logic [31:0] rdata;

   modport master (
      output req, we, lock, addr, wdata,
      input  gnt, ack, err, rdata
   );

   modport slave (
      input  req, we, lock, addr, wdata,
      output gnt, ack, err, rdata
   );
endinterface : periph_bus_arbiter_if
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter2
//  Brief    : Two-way round-robin grant logic with lockable bursts. The burst
//             budget is only consumed while the other master is requesting.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter2 import periph_bus_pkg::*; #(
   parameter int BURST_MAX = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_i,
   input  logic [1:0] lock_i,
   output logic [1:0] gnt_o
);

   localparam int              CNT_W   = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

   logic             last_q, last_d;
   logic             lock_act_q, lock_act_d;
   logic             lock_own_q, lock_own_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_base;
   logic             win;
   logic             lock_hold;
   logic             contended;

   assign contended = &req_i;

   // Arbitration state; m0 wins the first contention after reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q     <= M_DMA;
         lock_act_q <= 1'b0;
         lock_own_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         last_q     <= last_d;
         lock_act_q <= lock_act_d;
         lock_own_q <= lock_own_d;
         cnt_q      <= cnt_d;
      end
   end

   // Next state: update last grant, lock owner and burst budget on accept
   always_comb begin
      last_d     = last_q;
      lock_act_d = lock_act_q;
      lock_own_d = lock_own_q;
      cnt_d      = cnt_q;
      cnt_base   = '0;
      if (|req_i) begin
         last_d = win;
         if (lock_i[win]) begin
            lock_act_d = 1'b1;
            lock_own_d = win;
            // Continuing the same lock keeps its count, a new owner starts fresh
            cnt_base   = (lock_act_q && (lock_own_q == win)) ? cnt_q : '0;
            cnt_d      = (contended && (cnt_base < CNT_MAX)) ? cnt_base + 1'b1 : cnt_base;
         end else begin
            lock_act_d = 1'b0;
            cnt_d      = '0;
         end
      end else if (lock_act_q) begin
         // Owner let go of req with nobody else asking: drop the lock
         lock_act_d = 1'b0;
         cnt_d      = '0;
      end
   end

   // Grant selection: lone requester wins; otherwise lock budget, then round-robin
   always_comb begin
      lock_hold = lock_act_q & req_i[lock_own_q];
      win       = req_i[1] & ~req_i[0];
      if (contended) begin
         if (lock_hold) begin
            win = (cnt_q < CNT_MAX) ? lock_own_q : ~lock_own_q;
         end else begin
            win = ~last_q;
         end
      end
      gnt_o = {win, ~win} & {2{|req_i}};
   end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/periph_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : periph_bus_arbiter
//  Brief    : Shares the peripheral bus between CPU (m0) and DMA (m1).
//             Accept -> registered bus cycle -> registered ack/rdata.
//             Bad addresses are answered with err and never reach the bus.
//  Revision : 1.0  initial release
// ============================================================================
module periph_bus_arbiter import periph_bus_pkg::*; #(
   parameter logic [31:0] BASE_ADDR = PERIPH_BASE,
   parameter int          NUM_REGS  = PERIPH_NUM_REGS,
   parameter int          BURST_MAX = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   periph_bus_arbiter_if.slave  m0,
   periph_bus_arbiter_if.slave  m1,
   output logic                 Read,
   output logic                 Write,
   output logic [31:0]          addr,
   output logic [31:0]          wdata,
   input  logic [31:0]          rdata
);

   logic [1:0]  gnt;
   logic        acc;
   logic        sel;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_ok;

   // Command stage
   logic        cmd_vld_q;
   master_e     cmd_own_q;
   logic        cmd_err_q;
   logic        rd_q;
   logic        wr_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   // Response stage
   logic        ack0_d, ack0_q, ack1_d, ack1_q;
   logic        err0_d, err0_q, err1_d, err1_q;
   logic [31:0] rdata0_d, rdata0_q, rdata1_d, rdata1_q;
   logic        hit0, hit1;

   rr_arbiter2 #(
      .BURST_MAX (BURST_MAX)
   ) u_arb (
      .clk    (clk),
      .reset  (reset),
      .req_i  ({m1.req,  m0.req}),
      .lock_i ({m1.lock, m0.lock}),
      .gnt_o  (gnt)
   );

   assign m0.gnt    = gnt[0];
   assign m1.gnt    = gnt[1];

   assign acc       = |gnt;
   assign sel       = gnt[1];
   assign sel_we    = sel ? m1.we    : m0.we;
   assign sel_addr  = sel ? m1.addr  : m0.addr;
   assign sel_wdata = sel ? m1.wdata : m0.wdata;
   assign sel_ok    = addr_valid(sel_addr, BASE_ADDR, NUM_REGS);

   // Command register: strobes only for good addresses, addr/wdata hold otherwise
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_vld_q <= 1'b0;
         cmd_own_q <= M_CPU;
         cmd_err_q <= 1'b0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         cmd_vld_q <= acc;
         cmd_own_q <= master_e'(sel);
         cmd_err_q <= acc & ~sel_ok;
         rd_q      <= acc & sel_ok & ~sel_we;
         wr_q      <= acc & sel_ok &  sel_we;
         if (acc && sel_ok) begin
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
         end
      end
   end

   assign Read  = rd_q;
   assign Write = wr_q;
   assign addr  = addr_q;
   assign wdata = wdata_q;

   // Response next-state: route ack/err/rdata only to the owner of the bus cycle
   always_comb begin
      hit0     = cmd_vld_q && (cmd_own_q == M_CPU);
      hit1     = cmd_vld_q && (cmd_own_q == M_DMA);
      ack0_d   = hit0;
      ack1_d   = hit1;
      err0_d   = hit0 & cmd_err_q;
      err1_d   = hit1 & cmd_err_q;
      rdata0_d = (hit0 && rd_q) ? rdata : '0;
      rdata1_d = (hit1 && rd_q) ? rdata : '0;
   end

   // Response register: one-cycle ack pulse with sampled read data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         err0_q   <= err0_d;
         err1_q   <= err1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign m0.ack   = ack0_q;
   assign m0.err   = err0_q;
   assign m0.rdata = rdata0_q;
   assign m1.ack   = ack1_q;
   assign m1.err   = err1_q;
   assign m1.rdata = rdata1_q;

endmodule : periph_bus_arbiter
`default_nettype wire
